regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single register-file write port of the MIPS core between two writeback requesters: port A (ALU writeback) and port B (load/memory writeback). Each cycle it grants at most one requester through a valid/ready handshake. It decodes the granted 5-bit destination into a registered one-hot 32-bit write-enable vector. It also discards writes to register $0 and counts arbitration conflicts.

## Interface
Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, register address width; fixed at 5 (32 registers, enable vector 2**ADDR_W bits)
- CNT_W, 16, width of the conflict counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  register file cannot accept a write this cycle
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A's write is accepted this cycle (combinational)
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid  in  1  requester B has a write pending
- b_ready  out  1  B's write is accepted this cycle (combinational)
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write data
- wr_en  out  2**ADDR_W  registered one-hot write-enable to the register file; all-zero means no write
- wr_addr  out  ADDR_W  registered address of the last accepted write
- wr_data  out  DATA_W  registered data of the last accepted write
- last_grant  out  1  requester granted most recently (0 = A, 1 = B)
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests valid and stall low

## Operation
Grant rules:
- A handshake completes when valid && ready; ready never depends on the state of the other port's data.
- stall=1: a_ready = b_ready = 0.
- stall=0, exactly one requester valid: that requester is granted.
- stall=0, both valid, RR build: the requester other than last_grant is granted.
- stall=0, both valid, fixed build: A is granted.
- stall=0, neither valid: no grant.
- last_grant updates only on a grant; it holds during stall and idle cycles.

Output register, next edge after a grant:
- wr_addr and wr_data take the granted requester's address and data.
- wr_en takes a one-hot vector with bit[addr] set.
- If addr==0, wr_en is all-zero. The request is still accepted (ready=1) and wr_addr/wr_data still load.

Output register, next edge with no grant (including stall):
- wr_en goes to 0.
- wr_addr and wr_data hold.

Conflict counter:
- Increments by 1 when a_valid && b_valid && !stall.
- Saturates at 2**CNT_W-1 and never wraps.

Reset:
- wr_en=0, wr_addr=0, wr_data=0, conflict_cnt=0, last_grant=1, so A wins the first conflict in the RR build.
- Reset asserted mid-operation clears outputs asynchronously; a write granted in that cycle is lost.
- After reset deasserts, ready outputs follow the grant rules in the first cycle.

## Timing
- Arbitration is combinational from valid/stall to ready.
- Accept-to-wr_en latency is 1 cycle. Throughput is one write per cycle.
- wr_en is asserted for exactly one cycle per accepted nonzero write; back-to-back grants give consecutive one-hot pulses.
- A requester holding valid while not granted must keep its addr/data stable. The arbiter does not buffer losing requests.
- Worst-case wait in the RR build is one cycle under continuous contention (strict alternation A, B, A, B...).

## Configuration
- REGFILE_ARB_RR_EN defined: round-robin arbitration using last_grant.
- REGFILE_ARB_RR_EN undefined: fixed priority, A always wins a conflict; last_grant is still maintained for observation.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then a_valid=1, a_addr=5, a_data=0xDEADBEEF, stall=0 -> a_ready=1 same cycle; next cycle wr_en=0x00000020, wr_addr=5, wr_data=0xDEADBEEF; following idle cycle wr_en=0.
- RR build: both valid continuously for 4 cycles (A addr 1, B addr 2) -> grant order A, B, A, B; wr_en sequence 0x2, 0x4, 0x2, 0x4; conflict_cnt=4.
- Fixed build: same stimulus -> A granted all 4 cycles, b_ready=0 throughout, conflict_cnt=4.
- b_valid=1, b_addr=0, b_data=0x1234 -> b_ready=1; next cycle wr_en=0, wr_addr=0, wr_data=0x1234.
- stall=1 with both valid for 3 cycles -> both ready=0, wr_en=0, conflict_cnt unchanged, last_grant unchanged; deassert stall -> grant resumes per last_grant.
- Preload conflict_cnt to 0xFFFE through 0xFFFE contended cycles, then 3 more contended cycles -> holds at 0xFFFF. Assert reset mid-cycle -> all outputs 0 and last_grant=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single register-file write port, with a registered one-hot write-enable.
// Define REGFILE_ARB_RR_EN for round-robin conflict resolution; otherwise requester A has fixed priority.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic [2**ADDR_W-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 last_grant,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic                 a_wins_conflict;
  logic                 conflict;
  logic                 grant;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic [NREG-1:0]      en_next;

`ifdef REGFILE_ARB_RR_EN
  // last_grant==1 means B went last, so A gets the next conflict.
  assign a_wins_conflict = last_grant;
`else
  assign a_wins_conflict = 1'b1;
`endif

  assign conflict = a_valid && b_valid && !stall;

  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    if (!stall) begin
      a_ready = a_valid && (!b_valid || a_wins_conflict);
      b_ready = b_valid && (!a_valid || !a_wins_conflict);
    end
    grant    = a_ready || b_ready;
    sel_addr = b_ready ? b_addr : a_addr;
    sel_data = b_ready ? b_data : a_data;
  end

  // Register $0 is accepted but never enabled.
  always_comb begin
    en_next = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      en_next[i] = grant && (sel_addr != '0) && (sel_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en        <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      wr_en <= en_next;
      if (grant) begin
        wr_addr    <= sel_addr;
        wr_data    <= sel_data;
        last_grant <= b_ready;
      end
      if (conflict && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule
